hero_write_arb: RTL and testbench
=================================

# hero_write_arb

Parametrised N-channel arbiter for the hero write bus. Merges `NUM_CH` independent hero write sources onto one registered hero write output with round-robin fairness. Keeps every multi-beat transaction (VALID…DONE) contiguous. Adds ready/backpressure that the single-channel bus lacks. Sits between multiple bag-side hero write masters and the shared hero write sink.

## Interface

Parameters:
- `NUM_CH`, 4: number of input channels, 2..16.
- `DATA_W`, 36: hero write data width, defaults to HERO_WIDTH.
- `TIMEOUT`, 64: stall cycles before a lock is forcibly released; only used with the watchdog (see Configuration).

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `in_cycle_type`, in, 4*NUM_CH: per-channel cycle type.
  - Channel i occupies bits [4i+3:4i].
  - Encoding: IDLE=0, VALID=1, DONE=2. Values 3–15 are treated as IDLE.
- `in_wdat`, in, DATA_W*NUM_CH: per-channel write data.
- `in_clk_en`, in, NUM_CH: per-channel clock enable.
- `in_ready`, out, NUM_CH: beat on channel i is accepted when non-IDLE && `in_ready[i]`.
- `out_cycle_type`, out, 4: registered output cycle type.
- `out_wdat`, out, DATA_W: registered output data.
- `out_clk_en`, out, 1: registered output clock enable.
- `out_ch`, out, $clog2(NUM_CH): source channel of the current output beat.
- `out_ready`, in, 1: sink accepts the output beat when `out_cycle_type` != IDLE && `out_ready`.
- `err_timeout`, out, 1: one-cycle pulse when the watchdog releases a lock.

## Operation

States:
- ARB: no transaction open.
- LOCKED(ch): a VALID beat from `ch` has been accepted, DONE not yet.

Output register:
- "Free" when `out_cycle_type`==IDLE or `out_ready`==1.
- When free and no beat is accepted, it loads IDLE, wdat 0, clk_en 0. `out_ch` holds.

Arbitration and handshake:
- ARB:
  - Grant = first requesting channel (non-IDLE) searching from `rr_ptr`+1 modulo NUM_CH.
  - `in_ready[grant]` = output register free. All other `in_ready` are 0.
  - On acceptance: `rr_ptr` <= grant. VALID moves to LOCKED(grant). DONE (single-beat transaction) stays in ARB.
- LOCKED(ch):
  - Only `in_ready[ch]` may be 1; it equals output register free.
  - Accepted VALID keeps the lock. Accepted DONE returns to ARB.
  - IDLE from `ch` inserts no output beat; the lock is held.
  - Other channels stall (ready 0) and their data is held by the source.
- An accepted beat copies type/wdat/clk_en unchanged and sets `out_ch` to its channel.
- A DONE arriving in ARB with no preceding VALID is a legal single-beat transaction.

Reset values:
- All `in_ready` 0.
- `out_cycle_type` 0, `out_wdat` 0, `out_clk_en` 0, `out_ch` 0, `err_timeout` 0.
- State ARB. `rr_ptr` = NUM_CH-1, so channel 0 has first priority.
- Reset mid-transaction drops the lock and the output beat. No DONE is synthesised.

## Timing

- Input-to-output latency: 1 cycle.
  - A beat accepted at edge n appears on `out_*` after edge n.
- Full throughput: one beat per cycle while `out_ready`=1.
- Backpressure: `out_ready`=0 with a non-IDLE output deasserts all `in_ready` combinationally in the same cycle.
- `in_ready` depends combinationally on `in_cycle_type` (ARB only) and `out_ready`.
  - No combinational path from `in_wdat` to any output.
- Back-to-back transactions:
  - A new grant can be accepted in the cycle after DONE is accepted.
  - No bubble is required.
- Lock/arbitration changes take effect at the clock edge.
  - DONE acceptance and the next grant never occur in the same cycle.

## Configuration

Macro `HERO_WRITE_ARB_WATCHDOG_EN`.

Defined:
- In LOCKED, a counter (width $clog2(TIMEOUT+1)) increments each cycle the locked channel presents IDLE.
- The counter clears on any accepted beat and on leaving LOCKED.
- On reaching TIMEOUT, the next edge forces ARB and pulses `err_timeout` for 1 cycle.
- No DONE is emitted on the output.
- `rr_ptr` is set to the timed-out channel.

Undefined:
- No counter is built, `err_timeout` is tied to 0, and the lock is held indefinitely.

## Test plan

- **Reset priority.** Reset, then all 4 channels send a single DONE with wdat=0x1,0x2,0x3,0x4 held, `out_ready`=1.
  - Expect outputs in order ch0,ch1,ch2,ch3 on consecutive cycles, 1 cycle after each acceptance.
- **Contiguous transaction.** ch2 sends VALID,VALID,DONE (0xA,0xB,0xC) while ch1 requests continuously.
  - Expect out_ch=2 for three beats, then ch1 granted the next cycle.
- **Backpressure.** Hold `out_ready`=0 for 5 cycles during a ch0 VALID burst.
  - Expect `in_ready`=0 throughout and the output beat held stable.
  - Resume: no beat lost or duplicated.
- **Lock across IDLE gap.** ch3 sends VALID, IDLE×3, DONE while ch0 requests.
  - Expect ch0 stalled until ch3's DONE is accepted.
  - Output shows IDLE during the gap.
- **Async reset mid-transaction.** Assert `rst` after ch1's VALID.
  - Expect all outputs at reset values immediately and state ARB.
  - After release, ch0 wins over ch1.
- **Watchdog** (macro defined, TIMEOUT=8). ch1 sends VALID, then IDLE.
  - Expect `err_timeout` pulse after 8 IDLE cycles, then ch2 granted.
  - With macro undefined: ch2 never granted.

Source files
------------

// File: rtl/hero_write_arb.sv
// hero_write_arb: round-robin merge of NUM_CH hero write sources onto one registered
// output, keeping VALID..DONE transactions contiguous. Optional lock watchdog: HERO_WRITE_ARB_WATCHDOG_EN.

module hero_write_arb_lane #(
    parameter int DATA_W = 36
) (
    input  logic [3:0]        cycle_type,
    input  logic [DATA_W-1:0] wdat,
    input  logic              clk_en,
    input  logic              sel,
    output logic              req,
    output logic [3:0]        ct_m,
    output logic [DATA_W-1:0] wdat_m,
    output logic              clk_en_m
);
    // Only VALID and DONE request; every other code behaves as IDLE.
    assign req      = (cycle_type == 4'd1) || (cycle_type == 4'd2);
    assign ct_m     = sel ? cycle_type : 4'd0;
    assign wdat_m   = sel ? wdat : '0;
    assign clk_en_m = sel & clk_en;
endmodule

module hero_write_arb #(
    parameter int NUM_CH  = 4,
    parameter int DATA_W  = 36,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*NUM_CH-1:0]       in_cycle_type,
    input  logic [DATA_W*NUM_CH-1:0]  in_wdat,
    input  logic [NUM_CH-1:0]         in_clk_en,
    output logic [NUM_CH-1:0]         in_ready,
    output logic [3:0]                out_cycle_type,
    output logic [DATA_W-1:0]         out_wdat,
    output logic                      out_clk_en,
    output logic [$clog2(NUM_CH)-1:0] out_ch,
    input  logic                      out_ready,
    output logic                      err_timeout
);
    localparam int CH_W = $clog2(NUM_CH);
    localparam logic [3:0] CT_IDLE  = 4'd0;
    localparam logic [3:0] CT_VALID = 4'd1;
    localparam logic [3:0] CT_DONE  = 4'd2;

    if (NUM_CH < 2 || NUM_CH > 16 || TIMEOUT < 1) begin : g_param_err
        $error("hero_write_arb: NUM_CH must be 2..16 and TIMEOUT >= 1");
    end

    typedef enum logic {ARB, LOCKED} state_t;
    typedef struct packed {
        logic [3:0]        ctype;
        logic [DATA_W-1:0] wdat;
        logic              clk_en;
    } beat_t;

    state_t                        state;
    logic [CH_W-1:0]               lock_ch, rr_ptr, grant, sel, idx;
    logic                          grant_vld, out_free, accept, wd_fire;
    logic [NUM_CH-1:0]             req, sel_oh;
    logic [NUM_CH-1:0][3:0]        ct_m;
    logic [NUM_CH-1:0][DATA_W-1:0] wdat_m;
    logic [NUM_CH-1:0]             clk_en_m;
    beat_t                         out_q, sel_beat;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        hero_write_arb_lane #(.DATA_W(DATA_W)) u_lane (
            .cycle_type (in_cycle_type[4*i +: 4]),
            .wdat       (in_wdat[DATA_W*i +: DATA_W]),
            .clk_en     (in_clk_en[i]),
            .sel        (sel_oh[i]),
            .req        (req[i]),
            .ct_m       (ct_m[i]),
            .wdat_m     (wdat_m[i]),
            .clk_en_m   (clk_en_m[i])
        );
    end

    // Round-robin search starts one past the last granted channel.
    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        idx       = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = CH_W'((int'(rr_ptr) + k) % NUM_CH);
            if (!grant_vld && req[idx]) begin
                grant_vld = 1'b1;
                grant     = idx;
            end
        end
    end

    assign sel = (state == LOCKED) ? lock_ch : grant;

    always_comb begin
        sel_oh = '0;
        if (state == LOCKED || grant_vld) sel_oh[sel] = 1'b1;
    end

    always_comb begin
        sel_beat = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sel_beat.ctype  = sel_beat.ctype | ct_m[i];
            sel_beat.wdat   = sel_beat.wdat | wdat_m[i];
            sel_beat.clk_en = sel_beat.clk_en | clk_en_m[i];
        end
    end

    assign out_free = (out_q.ctype == CT_IDLE) || out_ready;
    assign in_ready = (out_free && !rst) ? sel_oh : '0;
    assign accept   = |(in_ready & req);

`ifdef HERO_WRITE_ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_cnt;

    assign wd_fire = (state == LOCKED) && !accept && (wd_cnt == WD_W'(TIMEOUT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                         wd_cnt <= '0;
        else if (state != LOCKED || accept || wd_fire)   wd_cnt <= '0;
        else if (!req[lock_ch])                          wd_cnt <= wd_cnt + WD_W'(1);
    end
`else
    assign wd_fire = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ARB;
            lock_ch     <= '0;
            rr_ptr      <= CH_W'(NUM_CH - 1);
            out_q       <= '0;
            out_ch      <= '0;
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= 1'b0;
            if (out_free) begin
                if (accept) begin
                    out_q  <= sel_beat;
                    out_ch <= sel;
                end else begin
                    out_q  <= '0;
                end
            end
            case (state)
                ARB: begin
                    if (accept) begin
                        rr_ptr <= sel;
                        if (sel_beat.ctype == CT_VALID) begin
                            state   <= LOCKED;
                            lock_ch <= sel;
                        end
                    end
                end
                LOCKED: begin
                    if (accept && sel_beat.ctype == CT_DONE) begin
                        state <= ARB;
                    end else if (wd_fire) begin
                        // Abandoned lock: reopen arbitration, source loses its turn.
                        state       <= ARB;
                        rr_ptr      <= lock_ch;
                        err_timeout <= 1'b1;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

    assign out_cycle_type = out_q.ctype;
    assign out_wdat       = out_q.wdat;
    assign out_clk_en     = out_q.clk_en;
endmodule

// File: tb/tb_hero_write_arb.sv
// Directed bench for hero_write_arb: priority, locking, backpressure, reset, watchdog.
`timescale 1ns/1ps
module tb_hero_write_arb;
    localparam int NUM_CH = 4, DATA_W = 36, TIMEOUT = 8;
    localparam logic [3:0] IDLE = 4'd0, VALID = 4'd1, DONE = 4'd2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [4*NUM_CH-1:0]      in_cycle_type;
    logic [DATA_W*NUM_CH-1:0] in_wdat;
    logic [NUM_CH-1:0]        in_clk_en;
    logic [NUM_CH-1:0]        in_ready;
    logic [3:0]               out_cycle_type;
    logic [DATA_W-1:0]        out_wdat;
    logic                     out_clk_en;
    logic [1:0]               out_ch;
    logic                     out_ready;
    logic                     err_timeout;

    int n_chk = 0, n_err = 0;

    hero_write_arb #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .in_cycle_type(in_cycle_type), .in_wdat(in_wdat),
        .in_clk_en(in_clk_en), .in_ready(in_ready), .out_cycle_type(out_cycle_type),
        .out_wdat(out_wdat), .out_clk_en(out_clk_en), .out_ch(out_ch),
        .out_ready(out_ready), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int ch, input logic [3:0] ct, input logic [DATA_W-1:0] wd, input logic ce);
        in_cycle_type[ch*4 +: 4]       = ct;
        in_wdat[ch*DATA_W +: DATA_W]   = wd;
        in_clk_en[ch]                  = ce;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] ct, input logic [DATA_W-1:0] wd,
                           input logic ce, input int ch);
        chk({tag, ".type"}, out_cycle_type, ct);
        chk({tag, ".wdat"}, out_wdat, wd);
        chk({tag, ".ce"},   out_clk_en, ce);
        chk({tag, ".ch"},   out_ch, ch);
    endtask

    task automatic chk_rdy(input string tag, input logic [NUM_CH-1:0] exp);
        #1;
        chk({tag, ".rdy"}, in_ready, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [NUM_CH-1:0] rdy_prev;
        int n_pulse, pulse_at, got2_at;

        rst = 1'b1; in_cycle_type = '0; in_wdat = '0; in_clk_en = '0; out_ready = 1'b1;
        repeat (2) step;

        // Reset priority: four single-beat DONEs held, channel 0 first.
        for (int i = 0; i < NUM_CH; i++) drive(i, DONE, DATA_W'(i + 1), 1'b1);
        chk_rdy("rst", 4'b0000);
        chk_out("rst", IDLE, 0, 1'b0, 0);
        chk("rst.err", err_timeout, 1'b0);
        rst = 1'b0;
        chk_rdy("t1.g0", 4'b0001);
        step; chk_out("t1.b0", DONE, 36'h1, 1'b1, 0); drive(0, IDLE, 0, 1'b0); chk_rdy("t1.g1", 4'b0010);
        step; chk_out("t1.b1", DONE, 36'h2, 1'b1, 1); drive(1, IDLE, 0, 1'b0); chk_rdy("t1.g2", 4'b0100);
        step; chk_out("t1.b2", DONE, 36'h3, 1'b1, 2); drive(2, IDLE, 0, 1'b0); chk_rdy("t1.g3", 4'b1000);
        step; chk_out("t1.b3", DONE, 36'h4, 1'b1, 3); drive(3, IDLE, 0, 1'b0); chk_rdy("t1.none", 4'b0000);
        step; chk_out("t1.idle", IDLE, 0, 1'b0, 3);

        // Contiguous transaction: ch2 burst while ch1 keeps requesting.
        drive(1, DONE, 36'h10, 1'b1); chk_rdy("t2.pre", 4'b0010);
        step; chk_out("t2.pre", DONE, 36'h10, 1'b1, 1);
        drive(1, DONE, 36'h11, 1'b1); drive(2, VALID, 36'hA, 1'b1); chk_rdy("t2.g", 4'b0100);
        step; chk_out("t2.b0", VALID, 36'hA, 1'b1, 2); drive(2, VALID, 36'hB, 1'b0); chk_rdy("t2.l0", 4'b0100);
        step; chk_out("t2.b1", VALID, 36'hB, 1'b0, 2); drive(2, DONE, 36'hC, 1'b1); chk_rdy("t2.l1", 4'b0100);
        step; chk_out("t2.b2", DONE, 36'hC, 1'b1, 2); drive(2, IDLE, 0, 1'b0); chk_rdy("t2.next", 4'b0010);
        step; chk_out("t2.b3", DONE, 36'h11, 1'b1, 1); drive(1, IDLE, 0, 1'b0);

        // Backpressure on a ch0 burst.
        drive(0, VALID, 36'h20, 1'b1); chk_rdy("t3.g", 4'b0001);
        step; chk_out("t3.b0", VALID, 36'h20, 1'b1, 0);
        drive(0, VALID, 36'h21, 1'b1); out_ready = 1'b0; chk_rdy("t3.bp", 4'b0000);
        for (int i = 0; i < 5; i++) begin
            step; chk_out("t3.hold", VALID, 36'h20, 1'b1, 0); chk_rdy("t3.hold", 4'b0000);
        end
        out_ready = 1'b1; chk_rdy("t3.res", 4'b0001);
        step; chk_out("t3.b1", VALID, 36'h21, 1'b1, 0); drive(0, DONE, 36'h22, 1'b1); chk_rdy("t3.l", 4'b0001);
        step; chk_out("t3.b2", DONE, 36'h22, 1'b1, 0); drive(0, IDLE, 0, 1'b0);
        step; chk_out("t3.idle", IDLE, 0, 1'b0, 0);

        // Lock held across an IDLE gap; ch0 stalls.
        drive(3, VALID, 36'h30, 1'b1); drive(0, DONE, 36'h40, 1'b1); chk_rdy("t4.g", 4'b1000);
        step; chk_out("t4.b0", VALID, 36'h30, 1'b1, 3); drive(3, IDLE, 0, 1'b0); chk_rdy("t4.gap", 4'b1000);
        for (int i = 0; i < 3; i++) begin
            step; chk_out("t4.gap", IDLE, 0, 1'b0, 3); chk_rdy("t4.gap", 4'b1000);
        end
        drive(3, DONE, 36'h31, 1'b1); chk_rdy("t4.done", 4'b1000);
        step; chk_out("t4.b1", DONE, 36'h31, 1'b1, 3); drive(3, IDLE, 0, 1'b0); chk_rdy("t4.next", 4'b0001);
        step; chk_out("t4.b2", DONE, 36'h40, 1'b1, 0); drive(0, IDLE, 0, 1'b0);

        // Async reset mid-transaction.
        drive(1, VALID, 36'h50, 1'b1); chk_rdy("t5.g", 4'b0010);
        step; chk_out("t5.b0", VALID, 36'h50, 1'b1, 1);
        drive(1, VALID, 36'h51, 1'b1); drive(0, DONE, 36'h60, 1'b1); chk_rdy("t5.l", 4'b0010);
        #2 rst = 1'b1;
        #1 chk_out("t5.rst", IDLE, 0, 1'b0, 0); chk_rdy("t5.rst", 4'b0000);
        step; rst = 1'b0; chk_rdy("t5.rel", 4'b0001);
        step; chk_out("t5.b1", DONE, 36'h60, 1'b1, 0); drive(0, IDLE, 0, 1'b0); chk_rdy("t5.g1", 4'b0010);
        step; chk_out("t5.b2", VALID, 36'h51, 1'b1, 1); drive(1, DONE, 36'h52, 1'b1); chk_rdy("t5.l1", 4'b0010);
        step; chk_out("t5.b3", DONE, 36'h52, 1'b1, 1); drive(1, IDLE, 0, 1'b0);

        // Watchdog: ch1 opens a lock and goes silent while ch2 waits.
        drive(1, VALID, 36'h70, 1'b1); chk_rdy("t6.g", 4'b0010);
        step; chk_out("t6.b0", VALID, 36'h70, 1'b1, 1);
        drive(1, IDLE, 0, 1'b0); drive(2, DONE, 36'h80, 1'b1); chk_rdy("t6.l", 4'b0010);
        n_pulse = 0; pulse_at = 0; got2_at = 0;
        for (int i = 1; i <= 20; i++) begin
            rdy_prev = in_ready;
            step;
            if (rdy_prev[2]) drive(2, IDLE, 0, 1'b0);
            if (err_timeout) begin
                n_pulse++;
                if (pulse_at == 0) pulse_at = i;
            end
            if (out_cycle_type != IDLE && out_ch == 2'd2 && got2_at == 0) got2_at = i;
            #1;
        end
`ifdef HERO_WRITE_ARB_WATCHDOG_EN
        chk("t6.pulse_at", pulse_at, 9);
        chk("t6.n_pulse", n_pulse, 1);
        chk("t6.ch2_at", got2_at, 10);
`else
        chk("t6.n_pulse", n_pulse, 0);
        chk("t6.ch2_at", got2_at, 0);
        chk_rdy("t6.still", 4'b0010);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
